// File: rtl/udp_packet_gen_axis.sv
// rtl/udp_packet_gen_axis.sv - IPv4/UDP pattern frame generator with AXI4-Stream master
module udp_packet_gen_axis #(
    parameter int          TDATA_W  = 64,
    parameter logic [31:0] SRC_IP   = 32'hC0A80001,
    parameter logic [15:0] SRC_PORT = 16'd5000,
    parameter logic [7:0]  TTL      = 8'h40
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   start,
    input  logic [15:0]            num_pkts,
    input  logic [10:0]            payload_len,
    input  logic [31:0]            dest_ip_addr,
    input  logic [15:0]            dest_port,
    input  logic [7:0]             ipg,
    input  logic                   abort,
    output logic                   busy,
    output logic                   done,
    output logic [31:0]            pkt_sent_cnt,
    output logic [TDATA_W-1:0]     tdata,
    output logic [TDATA_W/8-1:0]   tkeep,
    output logic                   tvalid,
    output logic                   tlast,
    input  logic                   tready
);

    localparam int         BPB     = TDATA_W / 8;
    localparam int         LW      = $clog2(BPB);
    localparam logic [10:0] MAX_LEN = 11'd1472;

    typedef enum logic [2:0] {S_IDLE, S_CSUM1, S_CSUM2, S_SEND, S_GAP} state_t;

    state_t      state_q, state_d;
    logic [15:0] num_q, num_d;
    logic [10:0] len_q, len_d;
    logic [31:0] dip_q, dip_d;
    logic [15:0] dport_q, dport_d;
    logic [7:0]  ipg_q, ipg_d;
    logic [7:0]  gap_q, gap_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] ident_q, ident_d;
    logic [31:0] pkt_cnt_q, pkt_cnt_d;
    logic [31:0] sum_q, sum_d;
    logic [15:0] csum_q, csum_d;
    logic [10:0] off_q, off_d;
    logic        abort_q, abort_d;
    logic        done_q, done_d;

    logic [10:0]    total_len;
    logic [15:0]    tot16, udp16;
    logic [31:0]    hdr_sum;
    logic [16:0]    fold1;
    logic [15:0]    fold2;
    logic [11:0]    off_end;
    logic           is_last;
    logic           abort_any;
    logic [LW-1:0]  rem;
    logic [BPB-1:0] last_keep;
    logic [7:0]     hdr [28];
    logic [10:0]    lane_idx;

    assign total_len = 11'd28 + len_q;
    assign tot16     = {5'd0, total_len};
    assign udp16     = {5'd0, 11'd8 + len_q};
    assign off_end   = {1'b0, off_q} + 12'(BPB);
    assign is_last   = (off_end >= {1'b0, total_len});
    assign abort_any = abort | abort_q;
    assign rem       = total_len[LW-1:0];
    assign last_keep = (rem == '0) ? '1 : ~({BPB{1'b1}} << rem);
    assign fold1     = {1'b0, sum_q[15:0]} + {1'b0, sum_q[31:16]};
    assign fold2     = fold1[15:0] + {15'd0, fold1[16]};

    // Header checksum is summed with its own field as zero; carries are folded one cycle later
    assign hdr_sum = {16'd0, 16'h4500} + {16'd0, tot16} + {16'd0, ident_q} + {16'd0, 16'h4000}
                   + {16'd0, TTL, 8'h11} + {16'd0, SRC_IP[31:16]} + {16'd0, SRC_IP[15:0]}
                   + {16'd0, dip_q[31:16]} + {16'd0, dip_q[15:0]};

    assign busy         = (state_q != S_IDLE);
    assign done         = done_q;
    assign pkt_sent_cnt = pkt_cnt_q;
    assign tvalid       = (state_q == S_SEND);
    assign tlast        = tvalid & is_last;
    assign tkeep        = tvalid ? (is_last ? last_keep : '1) : '0;

    // IPv4 + UDP header bytes in wire order (MSB of each field first)
    always_comb begin
        hdr[0]  = 8'h45;            hdr[1]  = 8'h00;
        hdr[2]  = tot16[15:8];      hdr[3]  = tot16[7:0];
        hdr[4]  = ident_q[15:8];    hdr[5]  = ident_q[7:0];
        hdr[6]  = 8'h40;            hdr[7]  = 8'h00;
        hdr[8]  = TTL;              hdr[9]  = 8'h11;
        hdr[10] = csum_q[15:8];     hdr[11] = csum_q[7:0];
        hdr[12] = SRC_IP[31:24];    hdr[13] = SRC_IP[23:16];
        hdr[14] = SRC_IP[15:8];     hdr[15] = SRC_IP[7:0];
        hdr[16] = dip_q[31:24];     hdr[17] = dip_q[23:16];
        hdr[18] = dip_q[15:8];      hdr[19] = dip_q[7:0];
        hdr[20] = SRC_PORT[15:8];   hdr[21] = SRC_PORT[7:0];
        hdr[22] = dport_q[15:8];    hdr[23] = dport_q[7:0];
        hdr[24] = udp16[15:8];      hdr[25] = udp16[7:0];
        hdr[26] = 8'h00;            hdr[27] = 8'h00;
    end

    // Beat assembly: each lane picks a header byte, a pattern byte, or zero past the frame end
    always_comb begin
        tdata    = '0;
        lane_idx = '0;
        if (state_q == S_SEND) begin
            for (int lane = 0; lane < BPB; lane++) begin
                lane_idx = off_q + 11'(lane);
                if (lane_idx < 11'd28)
                    tdata[8*lane +: 8] = hdr[lane_idx[4:0]];
                else if (lane_idx < total_len)
                    tdata[8*lane +: 8] = ident_q[7:0] + 8'(lane_idx - 11'd28);
            end
        end
    end

    // Next-state logic: burst sequencing, checksum pipeline, beat advance and abort handling
    always_comb begin
        state_d   = state_q;
        num_d     = num_q;
        len_d     = len_q;
        dip_d     = dip_q;
        dport_d   = dport_q;
        ipg_d     = ipg_q;
        gap_d     = gap_q;
        cnt_d     = cnt_q;
        ident_d   = ident_q;
        pkt_cnt_d = pkt_cnt_q;
        sum_d     = sum_q;
        csum_d    = csum_q;
        off_d     = off_q;
        abort_d   = abort_q | abort;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                abort_d = 1'b0;
                if (start) begin
                    num_d   = num_pkts;
                    len_d   = (payload_len > MAX_LEN) ? MAX_LEN : payload_len;
                    dip_d   = dest_ip_addr;
                    dport_d = dest_port;
                    ipg_d   = ipg;
                    cnt_d   = '0;
                    state_d = S_CSUM1;
                end
            end
            S_CSUM1: begin
                if (abort_any) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    sum_d   = hdr_sum;
                    state_d = S_CSUM2;
                end
            end
            S_CSUM2: begin
                if (abort_any) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    csum_d  = ~fold2;
                    off_d   = '0;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (tready) begin
                    if (is_last) begin
                        ident_d   = ident_q + 16'd1;
                        pkt_cnt_d = pkt_cnt_q + 32'd1;
                        cnt_d     = cnt_q + 16'd1;
                        if (abort_any || (num_q != 16'd0 && cnt_q + 16'd1 == num_q)) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end else if (ipg_q == 8'd0) begin
                            state_d = S_CSUM1;
                        end else begin
                            gap_d   = ipg_q;
                            state_d = S_GAP;
                        end
                    end else begin
                        off_d = off_q + 11'(BPB);
                    end
                end
            end
            S_GAP: begin
                if (abort_any) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else if (gap_q <= 8'd1) begin
                    state_d = S_CSUM1;
                end else begin
                    gap_d = gap_q - 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register with synchronous active-low reset
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q   <= S_IDLE;
            num_q     <= '0;
            len_q     <= '0;
            dip_q     <= '0;
            dport_q   <= '0;
            ipg_q     <= '0;
            gap_q     <= '0;
            cnt_q     <= '0;
            ident_q   <= '0;
            pkt_cnt_q <= '0;
            sum_q     <= '0;
            csum_q    <= '0;
            off_q     <= '0;
            abort_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            num_q     <= num_d;
            len_q     <= len_d;
            dip_q     <= dip_d;
            dport_q   <= dport_d;
            ipg_q     <= ipg_d;
            gap_q     <= gap_d;
            cnt_q     <= cnt_d;
            ident_q   <= ident_d;
            pkt_cnt_q <= pkt_cnt_d;
            sum_q     <= sum_d;
            csum_q    <= csum_d;
            off_q     <= off_d;
            abort_q   <= abort_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: doc/udp_packet_gen_axis.md
Name: udp_packet_gen_axis

Overview:
- Parametrised IPv4/UDP packet generator. Successor to the fixed 64-bit IP packet generator.
- Builds complete IPv4 + UDP frames: 20 B IP header, 8 B UDP header, programmable-length pattern payload.
- Emits frames on an AXI4-Stream master of configurable width; tready back-pressure is fully honoured.
- Adds packet bursts, an inter-packet gap, a computed IPv4 header checksum, abort, and status counters. Feeds the SRIO/UDP transmit path.

Parameters:
- TDATA_W, 64, stream data width in bits; legal values 32, 64, 128; TKEEP width = TDATA_W/8.
- SRC_IP, 32'hC0A80001, IPv4 source address.
- SRC_PORT, 16'd5000, UDP source port.
- TTL, 8'h40, IPv4 time-to-live.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  synchronous reset, active low.
- start  in  1  one-cycle request; sampled only in IDLE.
- num_pkts  in  16  packets per burst; 0 = run until abort.
- payload_len  in  11  UDP payload bytes; 0..1472; values above 1472 are clamped to 1472.
- dest_ip_addr  in  32  IPv4 destination address.
- dest_port  in  16  UDP destination port.
- ipg  in  8  idle cycles inserted after each tlast handshake.
- abort  in  1  stop after the current packet.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse when a burst ends.
- pkt_sent_cnt  out  32  total packets completed since reset; wraps.
- tdata  out  TDATA_W  stream data; frame byte k of a beat sits on tdata[8k+7:8k].
- tkeep  out  TDATA_W/8  byte enables.
- tvalid  out  1  stream valid.
- tlast  out  1  last beat of the frame.
- tready  in  1  sink ready.

Behaviour:
- Reset (aresetn=0 at aclk edge): state IDLE; tvalid, tlast, busy, done = 0; tdata, tkeep = 0; pkt_sent_cnt = 0; identification counter = 0.
- Reset applied mid-packet: tvalid drops the next cycle and the frame is truncated; no recovery of the partial frame.
- State machine: IDLE -> CSUM -> SEND -> GAP -> CSUM ... -> IDLE.
- IDLE: when start=1 at cycle N, latch num_pkts, payload_len, dest_ip_addr, dest_port, ipg; go to CSUM.
  - Inputs are not re-sampled until the next IDLE.
  - start while busy is ignored.
- CSUM lasts exactly 2 cycles: cycle 1 forms the 32-bit sum of the ten header words; cycle 2 folds the carries and complements.
  - First tvalid is asserted in cycle N+3.
- Header fields:
  - Word 0x4500.
  - Total length = 28 + len.
  - Identification = ident counter.
  - Flags/fragment = 0x4000.
  - TTL / protocol = {TTL, 8'h11}.
  - Header checksum.
  - SRC_IP, then dest IP.
  - UDP: src port, dest port, length = 8 + len, checksum 0x0000.
- All multi-byte fields are in network order: the MSB is at the lower frame byte index.
- Payload byte i = (ident[7:0] + i) mod 256.
- Beats per frame = ceil((28 + len) / (TDATA_W/8)).
  - tkeep is all ones except on the last beat, where it has the low r bits set; r = (28 + len) mod bytes-per-beat, or all ones if r = 0.
- SEND: standard AXIS rules.
  - Once tvalid=1, tdata/tkeep/tlast hold until tvalid&&tready.
  - The beat advances only on a handshake.
  - tvalid never drops mid-frame except on reset.
- On the tlast handshake:
  - ident increments (wraps 0xFFFF->0); pkt_sent_cnt increments; the burst counter increments.
  - If the burst is complete (count == num_pkts, num_pkts != 0) or abort was seen: go to IDLE and pulse done in the following cycle.
  - Otherwise go to GAP.
- GAP: tvalid=0 for ipg cycles (ipg=0 -> 0 cycles), then CSUM.
  - Minimum spacing between tlast and the next first beat is ipg+2 idle cycles.
- abort:
  - Sticky from assertion until IDLE.
  - Asserted in GAP or CSUM: go directly to IDLE with the done pulse; no further tvalid.
  - Asserted in SEND: the current frame completes.
  - Ignored in IDLE.
- Simultaneous abort and tlast handshake: the burst ends; done pulses.

Test Plan:
- TDATA_W=64, dest 0xDDCCBBAA, port 1024, len=5, num_pkts=1, tready=1, start at N:
  - tvalid high at N+3; 5 beats.
  - Beat0 tdata=64'h0040000021000045.
  - Checksum 0xE0AB in beat1 bytes 2-3.
  - Last beat tkeep=8'h01 with tlast; done pulse; pkt_sent_cnt=1.
- Same config, tready toggling 1-0-0-1 per cycle:
  - tdata stable while stalled; identical byte stream to the first test.
  - No beat dropped or duplicated.
- num_pkts=3, ipg=4, len=8:
  - 3 frames with identification 0, 1, 2 and payload starting 0x00, 0x01, 0x02.
  - 6 idle cycles between frames; single done pulse after frame 3.
- num_pkts=0, abort raised mid-frame 2:
  - Frame 2 completes with tlast; no frame 3; done pulses; busy low the next cycle.
- TDATA_W=32 and 128 with len=0:
  - 28-byte frames: 7 beats with all-ones last tkeep (32-bit); 2 beats with last tkeep=16'h0FFF (128-bit).
  - len=1500 input clamped to UDP length 1480.
- aresetn low during SEND beat 3:
  - Next cycle tvalid=0 and pkt_sent_cnt=0.
  - A new start yields identification 0.
